// File: rtl/battleship_pkg.sv
// Shared types and helpers for the battleship shot/turn logic.
package battleship_pkg;

  localparam int GRID_SIZE = 10;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    MISS = 2'd1,
    NEAR = 2'd2,
    HIT  = 2'd3
  } result_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    SCORE    = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  // True when a coordinate lies on the board (1..GRID_SIZE).
  function automatic logic coord_ok(input logic [3:0] c);
    return (c >= 4'd1) && (c <= 4'(GRID_SIZE));
  endfunction

  // Row-major cell number of a 1-based (x,y); only meaningful when both are on the board.
  function automatic logic [6:0] cell_index(input logic [3:0] x, input logic [3:0] y);
    logic [6:0] row;
    logic [6:0] col;
    row = {3'd0, y} - 7'd1;
    col = {3'd0, x} - 7'd1;
    return (row * 7'(GRID_SIZE)) + col;
  endfunction

endpackage

// File: rtl/shot_history.sv
// Bitmap of board cells already targeted; one bit per cell, cleared on reset.
module shot_history
  import battleship_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] Idx,
  input  logic       Mark,
  output logic       Seen
);

  localparam int CELLS = GRID_SIZE * GRID_SIZE;

  logic [CELLS-1:0] map_r;
  logic             in_grid_s;

  assign in_grid_s = (Idx < 7'(CELLS));

  // Set the addressed cell when a shot is scored; indices past the board are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      map_r <= '0;
    end else if (Mark && in_grid_s) begin
      map_r[Idx] <= 1'b1;
    end
  end

  // Combinational lookup; off-board indices read as not seen.
  always_comb begin
    if (in_grid_s) begin
      Seen = map_r[Idx];
    end else begin
      Seen = 1'b0;
    end
  end

endmodule

// File: rtl/shot_turn_controller.sv
// Turn controller: latches a fire request, validates it, strobes the scoring
// stage for one cycle, then updates shot/bomb/hit counters and game status.
module shot_turn_controller
  import battleship_pkg::*;
#(
  parameter int MAX_SHOTS   = 30,
  parameter int BIG_BOMBS   = 3,
  parameter int HITS_TO_WIN = 17
)
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Big,
  input  logic       Score,
  input  logic       Hit,
  input  logic       NearMiss,
  input  logic       Miss,
  output logic [3:0] ScoreX,
  output logic [3:0] ScoreY,
  output logic       ScoreBig,
  output logic       ScoreThis,
  output logic       Wrong,
  output result_t    LastResult,
  output logic [5:0] ShotsLeft,
  output logic [1:0] BigLeft,
  output logic [4:0] HitCount,
  output logic       GameOver,
  output logic       Win
);

  localparam logic [5:0] SHOTS_INIT = 6'(MAX_SHOTS);
  localparam logic [1:0] BIG_INIT   = 2'(BIG_BOMBS);
  localparam logic [4:0] WIN_HITS   = 5'(HITS_TO_WIN);

  state_t     state_r;
  logic       score_prev_r;
  logic       fire_s;
  logic       reject_s;
  logic       seen_s;
  logic       mark_s;
  logic [6:0] idx_s;
  logic [4:0] hits_next_s;
  logic [5:0] shots_next_s;
  result_t    result_s;

  // Remember the previous button level; starts high so a button held through reset does not fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      score_prev_r <= 1'b1;
    end else begin
      score_prev_r <= Score;
    end
  end

  assign fire_s = Score & ~score_prev_r;
  assign idx_s  = cell_index(ScoreX, ScoreY);
  assign mark_s = (state_r == SCORE);

  shot_history u_history (
    .clock (clock),
    .reset (reset),
    .Idx   (idx_s),
    .Mark  (mark_s),
    .Seen  (seen_s)
  );

  // Validate the latched target and precompute the post-shot counter values.
  always_comb begin
    reject_s = ~coord_ok(ScoreX) | ~coord_ok(ScoreY) |
               (ScoreBig & (BigLeft == 2'd0)) | seen_s;
    if (Hit) begin
      result_s = HIT;
    end else if (NearMiss) begin
      result_s = NEAR;
    end else begin
      result_s = MISS;
    end
    if (Hit && (HitCount != 5'd31)) begin
      hits_next_s = HitCount + 5'd1;
    end else begin
      hits_next_s = HitCount;
    end
    shots_next_s = ShotsLeft - 6'd1;
  end

  // Turn FSM; every output and counter is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      ScoreX     <= 4'd0;
      ScoreY     <= 4'd0;
      ScoreBig   <= 1'b0;
      ScoreThis  <= 1'b0;
      Wrong      <= 1'b0;
      LastResult <= NONE;
      ShotsLeft  <= SHOTS_INIT;
      BigLeft    <= BIG_INIT;
      HitCount   <= 5'd0;
      GameOver   <= 1'b0;
      Win        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (fire_s) begin
            ScoreX   <= X;
            ScoreY   <= Y;
            ScoreBig <= Big;
            Wrong    <= 1'b0;
            state_r  <= CHECK;
          end
        end
        CHECK: begin
          if (reject_s) begin
            Wrong    <= 1'b1;
            ScoreBig <= 1'b0;
            state_r  <= IDLE;
          end else begin
            ScoreThis <= 1'b1;
            state_r   <= SCORE;
          end
        end
        SCORE: begin
          ScoreThis  <= 1'b0;
          ShotsLeft  <= shots_next_s;
          HitCount   <= hits_next_s;
          LastResult <= result_s;
          if (ScoreBig) begin
            BigLeft <= BigLeft - 2'd1;
          end
          // A winning hit on the last shot counts as a win.
          if (hits_next_s == WIN_HITS) begin
            GameOver <= 1'b1;
            Win      <= 1'b1;
            state_r  <= GAMEOVER;
          end else if (shots_next_s == 6'd0) begin
            GameOver <= 1'b1;
            Win      <= 1'b0;
            state_r  <= GAMEOVER;
          end else begin
            state_r <= IDLE;
          end
        end
        GAMEOVER: begin
          GameOver  <= 1'b1;
          ScoreThis <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
